// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults, helpers and parameter legality check for fifo_sync
package fifo_pkg;

    localparam int WIDTH_DEF        = 8;
    localparam int DEPTH_LOG2_DEF   = 4;
    localparam int AFULL_LEVEL_DEF  = 8;
    localparam int AEMPTY_LEVEL_DEF = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`define FIFO_LEVELS_LEGAL(dl2, af, ae) \
    ((dl2) >= 1 && (dl2) <= 10 && (af) >= 1 && (af) <= (1 << (dl2)) && (ae) >= 0 && (ae) < (1 << (dl2)))

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - simple dual-port storage; registered read, combinational under FIFO_FWFT_EN
module fifo_ram #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

`ifdef FIFO_FWFT_EN
    assign rdata = mem_q[raddr];
`else
    logic [WIDTH-1:0] rdata_q;

    // Only the output register is reset; the array stays reset-free so it can map to RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;
`endif

endmodule

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - synchronous FIFO with thresholds, flush and sticky errors; FIFO_FWFT_EN selects fall-through reads
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int DEPTH_LOG2   = DEPTH_LOG2_DEF,
    parameter int AFULL_LEVEL  = AFULL_LEVEL_DEF,
    parameter int AEMPTY_LEVEL = AEMPTY_LEVEL_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic [WIDTH-1:0]    wrdata,
    input  logic                wr_en,
    output logic [WIDTH-1:0]    rddata,
    input  logic                rd_en,
    output logic                empty,
    output logic                full,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [DEPTH_LOG2:0] count,
    output logic                overflow,
    output logic                underflow
);

    localparam int AW    = DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;

    typedef logic [AW:0] ptr_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);
    localparam ptr_t AF_LVL  = ptr_t'(AFULL_LEVEL);
    localparam ptr_t AE_LVL  = ptr_t'(AEMPTY_LEVEL);

    if (!`FIFO_LEVELS_LEGAL(DEPTH_LOG2, AFULL_LEVEL, AEMPTY_LEVEL)) begin : g_bad_params
        $error("fifo_sync: DEPTH_LOG2 or threshold parameter out of range");
    end

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;
    logic wr_acc, rd_acc;

    // Extra wrap bit distinguishes full from empty when the low address bits match.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = wr_en && !full && !flush;
    assign rd_acc = rd_en && !empty && !flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (wr_en && full)  overflow_d  = 1'b1;
            if (rd_en && empty) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (wrdata),
        .re    (rd_acc),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rddata)
    );

endmodule
